gate_array_pipe: RTL
====================

# gate_array_pipe

Parametrised, registered successor to the two-input basic-gate block. It applies one of eight bitwise logic functions across WIDTH-bit operand vectors and delivers the result through a one-deep pipeline register with valid/ready flow control. It also reports result flags and a saturating transaction count. It sits between operand sources and any downstream consumer that needs back-pressure.

## Interface
Parameters:
- WIDTH, 8, operand/result width in bits (≥1)
- CNT_W, 16, width of the transaction counter (≥2)

Ports:
- clk  input  1  single clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- A  input  WIDTH  operand A
- B  input  WIDTH  operand B
- op  input  3  function select
- acc  input  1  use last result in place of B (only with GATE_ACC_EN)
- in_valid  input  1  operands/op valid
- in_ready  output  1  block can accept this cycle
- Y  output  WIDTH  registered result
- zero  output  1  Y == 0
- ones  output  1  Y == all ones
- out_valid  output  1  Y/flags valid
- out_ready  input  1  consumer accepts this cycle
- count  output  CNT_W  number of results delivered, saturating

## Operation
- Opcodes, bitwise per bit: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6 NOT A (B ignored), 7 PASS A (B ignored).
- Input accept: in_valid && in_ready. On accept, Y ← f(op, A, Bsel), zero/ones are computed from the new Y, and out_valid ← 1.
- in_ready = !out_valid || out_ready. This is a combinational pass-through of out_ready and gives full throughput with no bubble.
- Output transfer: out_valid && out_ready. On transfer with no simultaneous accept, out_valid ← 0. On simultaneous transfer and accept, out_valid stays 1 and Y is replaced.
- While out_valid=1 and out_ready=0, Y, zero, ones and out_valid hold stable. Inputs are not sampled.
- count increments by 1 on each output transfer. It saturates at 2^CNT_W−1 and does not wrap.
- Bsel = B, except as described under Configuration.
- States, implicit: EMPTY (out_valid=0) and FULL (out_valid=1).
  - EMPTY → FULL on accept.
  - FULL → EMPTY on transfer without accept.
  - FULL → FULL on hold, or on transfer with accept.

## Timing
- Latency is 1 cycle, from the accept edge to out_valid=1 with Y valid.
- Throughput is 1 result/cycle when out_ready is held high.
- Reset values: Y=0, zero=1, ones=0, out_valid=0, count=0, last-result register=0. in_ready=1 in the first cycle after reset.
- Reset mid-operation: a pending unconsumed result is discarded, with no transfer and no count increment. Reset overrides a simultaneous accept or transfer.
- WIDTH=1: zero and ones are complementary whenever out_valid=1.

## Configuration
- Macro GATE_ACC_EN.
- Defined:
  - A register `last` captures Y on every accept.
  - When acc=1 on an accept, Bsel = last instead of B. This allows chaining, e.g. running XOR.
  - `last` survives output transfers and is cleared only by rst.
- Not defined:
  - The acc input is ignored and Bsel = B always.
  - No `last` register is instantiated.
  - The port still exists.

## Test plan
- Reset then gate sweep, WIDTH=8, A=8'hF0, B=8'hCC, out_ready=1, op 0..7 on consecutive cycles → Y = C0, FC, 3F, 03, 3C, C3, 0F, F0, one cycle after each accept; count=8 at end.
- Flags: A=8'h0F, B=8'hF0 → AND gives Y=00 with zero=1, ones=0. OR gives Y=FF with ones=1, zero=0.
- Back-pressure: accept op=4 with A=8'hAA, B=8'h55, then hold out_ready=0 for 5 cycles → Y=FF stays stable, in_ready=0, count unchanged. Raising out_ready together with a new in_valid gives a transfer and accept in the same cycle, with out_valid staying 1.
- Saturation, CNT_W=2: deliver 6 results → count goes 1, 2, 3, 3, 3, 3.
- Reset mid-operation: accept a result, hold out_ready=0, assert rst for 1 cycle → out_valid=0, Y=0, count=0, in_ready=1 on the next cycle.
- GATE_ACC_EN: op=4, acc=0, A=8'h01, B=8'h00 → Y=01. Then op=4, acc=1, A=8'h02 → Y=03. Then A=8'h04 → Y=07. Without the macro, the same stimulus with B=8'h00 gives Y = 01, 02, 04.

Source files
------------

// File: rtl/gate_array_pipe.sv
// Registered bitwise gate array with one-deep valid/ready output stage, result flags
// and a saturating delivery counter. Define GATE_ACC_EN to add the result-chaining register.
module gate_array_pipe #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       op,
    input  logic             acc,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] Y,
    output logic             zero,
    output logic             ones,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] count
);

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_NAND = 3'd2;
    localparam logic [2:0] OP_NOR  = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_XNOR = 3'd5;
    localparam logic [2:0] OP_NOTA = 3'd6;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             zero_q, zero_d;
    logic             ones_q, ones_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] bsel;
    logic [WIDTH-1:0] res;
    logic             accept;
    logic             xfer;

`ifdef GATE_ACC_EN
    logic [WIDTH-1:0] last_q, last_d;

    // Chained operation: substitute the previously accepted result for B
    assign bsel = acc ? last_q : B;
`else
    logic unused_acc;

    assign unused_acc = acc;
    assign bsel       = B;
`endif

    assign out_valid = (state_q == S_FULL);
    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign xfer      = out_valid && out_ready;
    assign Y         = y_q;
    assign zero      = zero_q;
    assign ones      = ones_q;
    assign count     = cnt_q;

    // Bitwise function select
    always_comb begin
        res = '0;
        case (op)
            OP_AND:  res = A & bsel;
            OP_OR:   res = A | bsel;
            OP_NAND: res = ~(A & bsel);
            OP_NOR:  res = ~(A | bsel);
            OP_XOR:  res = A ^ bsel;
            OP_XNOR: res = ~(A ^ bsel);
            OP_NOTA: res = ~A;
            default: res = A;
        endcase
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        zero_d  = zero_q;
        ones_d  = ones_q;
        cnt_d   = cnt_q;
`ifdef GATE_ACC_EN
        last_d  = last_q;
`endif

        case (state_q)
            S_EMPTY: if (accept)         state_d = S_FULL;
            S_FULL:  if (xfer && !accept) state_d = S_EMPTY;
            default:                     state_d = S_EMPTY;
        endcase

        if (accept) begin
            y_d    = res;
            zero_d = (res == '0);
            ones_d = (res == '1);
`ifdef GATE_ACC_EN
            last_d = res;
`endif
        end

        if (xfer && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_EMPTY;
            y_q     <= '0;
            zero_q  <= 1'b1;
            ones_q  <= 1'b0;
            cnt_q   <= '0;
`ifdef GATE_ACC_EN
            last_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            zero_q  <= zero_d;
            ones_q  <= ones_d;
            cnt_q   <= cnt_d;
`ifdef GATE_ACC_EN
            last_q  <= last_d;
`endif
        end
    end

endmodule
